dot_matrix_scan_ctrl: RTL

Scan scheduler for the 8x8 LED dot-matrix display. It owns the row-strobe sequence and drives the active-low row select. It fetches each row's column pattern from an internal double-buffered frame store. Frame swaps requested by the pattern generator are applied only at frame boundaries, so a displayed frame never tears. Sits between the pattern/animation logic and the matrix pins.

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_frame_buf.sv | 47 ++++
 rtl/dot_matrix_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the 8x8 dot-matrix scan controller.
package dm_pkg;

  localparam int DM_ROWS = 8;
  localparam int DM_COLS = 8;

  localparam logic [7:0] ROW_OFF = 8'hFF;
  localparam logic [7:0] COL_OFF = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } dm_state_e;

  // Active-low one-hot strobe for a row index.
  function automatic logic [7:0] row_strobe(input logic [2:0] idx);
    row_strobe = ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/dm_frame_buf.sv
// Double-buffered 8x8 frame store: writes land in the back bank, reads come from the front bank.
module dm_frame_buf
  import dm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_row,
  input  logic [DM_COLS-1:0]   wr_data,
  input  logic                 toggle,
  input  logic [2:0]           rd_row,
  output logic [DM_COLS-1:0]   rd_data
);

  logic [DM_COLS-1:0] bank_r [2][DM_ROWS];
  logic               front_sel_r;
  logic               wr_bank_s;
  logic               rd_bank_s;

  assign wr_bank_s = ~front_sel_r;
  // The read looks through a swap happening at this edge so the caller registers the new front's data.
  assign rd_bank_s = front_sel_r ^ toggle;
  assign rd_data   = bank_r[rd_bank_s][rd_row];

  // front bank select, flipped by each executed swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel_r <= 1'b0;
    end else begin
      front_sel_r <= front_sel_r ^ toggle;
    end
  end

  // back-bank write port; both banks clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < DM_ROWS; r++) begin
          bank_r[b][r] <= COL_OFF;
        end
      end
    end else if (wr_en) begin
      bank_r[wr_bank_s][wr_row] <= wr_data;
    end
  end

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-strobe scheduler for the 8x8 LED matrix with per-slot blanking and tear-free frame swaps.
module dot_matrix_scan_ctrl
  import dm_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [2:0] sw,
  output logic [7:0] row,
  output logic [7:0] col
);

  localparam int            CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam bit            HAS_BLANK  = (BLANK > 0);

  dm_state_e     state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    sw_r, sw_s;
  logic          wrap_s, start_s;
  logic          pending_r, pending_s, swap_do_s;
  logic          swap_ack_r, frame_start_r;
  logic [7:0]    row_r, row_s, col_r, col_s;
  logic [7:0]    rd_data_s;

  dm_frame_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .toggle  (swap_do_s),
    .rd_row  (sw_s),
    .rd_data (rd_data_s)
  );

  // next scan position: state, dwell count and row index
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    sw_s    = sw_r;
    wrap_s  = 1'b0;
    start_s = 1'b0;
    if (!en) begin
      state_s = ST_IDLE;
      cnt_s   = '0;
      sw_s    = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_s   = '0;
          sw_s    = 3'd0;
          start_s = 1'b1;
          state_s = HAS_BLANK ? ST_BLANK : ST_DRIVE;
        end
        ST_BLANK: begin
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == BLANK_LAST) begin
            state_s = ST_DRIVE;
          end else begin
            state_s = ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = '0;
            sw_s    = sw_r + 3'd1;
            state_s = HAS_BLANK ? ST_BLANK : ST_DRIVE;
            if (sw_r == 3'd7) begin
              wrap_s  = 1'b1;
              start_s = 1'b1;
            end else begin
              wrap_s  = 1'b0;
              start_s = 1'b0;
            end
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
            state_s = ST_DRIVE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          sw_s    = 3'd0;
        end
      endcase
    end
  end

  // swap only at the 7->0 wrap, or immediately while parked; ack masks the request for one cycle
  always_comb begin
    swap_do_s = pending_r & ((state_r == ST_IDLE) | wrap_s);
    if (swap_do_s) begin
      pending_s = 1'b0;
    end else if (swap_req && !swap_ack_r) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // pin values for the cycle after this edge
  always_comb begin
    if (state_s == ST_DRIVE) begin
      row_s = row_strobe(sw_s);
      col_s = rd_data_s;
    end else begin
      row_s = ROW_OFF;
      col_s = COL_OFF;
    end
  end

  // FSM, counter and pending-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      sw_r      <= 3'd0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      sw_r      <= sw_s;
      pending_r <= pending_s;
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r         <= ROW_OFF;
      col_r         <= COL_OFF;
      swap_ack_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      row_r         <= row_s;
      col_r         <= col_s;
      swap_ack_r    <= swap_do_s;
      frame_start_r <= start_s;
    end
  end

  assign row         = row_r;
  assign col         = col_r;
  assign sw          = sw_r;
  assign swap_ack    = swap_ack_r;
  assign frame_start = frame_start_r;

endmodule
